// File: rtl/sqrt_rom_arbiter_if.sv
// Handshake and ROM bus of the two-channel sqrt lookup arbiter.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface sqrt_rom_arbiter_if #(
    parameter int W_DATA = 16,
    parameter int W_ADDR = 8
);
    logic [W_ADDR-1:0] din0_data;
    logic              din0_valid;
    logic              din0_ready;
    logic [W_DATA-1:0] dout0_data;
    logic              dout0_valid;
    logic              dout0_ready;

    logic [W_ADDR-1:0] din1_data;
    logic              din1_valid;
    logic              din1_ready;
    logic [W_DATA-1:0] dout1_data;
    logic              dout1_valid;
    logic              dout1_ready;

    logic              rom_ena;
    logic [W_ADDR-1:0] rom_addra;
    logic [W_DATA-1:0] rom_doa;

    modport slave (
        input  din0_data, din0_valid, dout0_ready,
        input  din1_data, din1_valid, dout1_ready,
        input  rom_doa,
        output din0_ready, dout0_data, dout0_valid,
        output din1_ready, dout1_data, dout1_valid,
        output rom_ena, rom_addra
    );

    modport master (
        output din0_data, din0_valid, dout0_ready,
        output din1_data, din1_valid, dout1_ready,
        output rom_doa,
        input  din0_ready, dout0_data, dout0_valid,
        input  din1_ready, dout1_data, dout1_valid,
        input  rom_ena, rom_addra
    );
endinterface

// File: rtl/sqrt_rom_arbiter.sv
// Round-robin sharing of one single-port sqrt ROM between two request channels,
// with a per-channel output FIFO whose slot is reserved at grant time.
module sqrt_rom_arbiter #(
    parameter int W_DATA    = 16,
    parameter int W_ADDR    = 8,
    parameter int OUT_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    sqrt_rom_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [W_ADDR-1:0] din_data [2];
    logic [W_DATA-1:0] dout_data [2];
    logic [1:0]        din_valid;
    logic [1:0]        dout_ready;
    logic [1:0]        dout_valid;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        infl;
    logic [1:0]        push;
    logic [1:0]        pop;

    logic              rr_reg;
    logic              tag_v_reg;
    logic              tag_ch_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign din_data[0]     = bus.din0_data;
    assign din_data[1]     = bus.din1_data;
    assign din_valid       = {bus.din1_valid, bus.din0_valid};
    assign dout_ready      = {bus.dout1_ready, bus.dout0_ready};
    assign bus.din0_ready  = grant[0];
    assign bus.din1_ready  = grant[1];
    assign bus.dout0_data  = dout_data[0];
    assign bus.dout1_data  = dout_data[1];
    assign bus.dout0_valid = dout_valid[0];
    assign bus.dout1_valid = dout_valid[1];

    always_comb begin
        grant = 2'b00;
        if (elig == 2'b11) begin
            grant = rr_reg ? 2'b10 : 2'b01;
        end else begin
            grant = elig;
        end
    end

    assign bus.rom_ena   = |grant;
    assign bus.rom_addra = grant[1] ? din_data[1] :
                           grant[0] ? din_data[0] : '0;

    // The tag follows the ROM's one-cycle read so the returning word finds its FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_reg     <= 1'b0;
            tag_v_reg  <= 1'b0;
            tag_ch_reg <= 1'b0;
        end else begin
            tag_v_reg  <= bus.rom_ena;
            tag_ch_reg <= grant[1];
            if (bus.rom_ena) begin
                rr_reg <= grant[0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [OCC_W-1:0]  occ_reg;
            logic [OCC_W-1:0]  occ_next;
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [OCC_W:0]    load;
            logic [W_DATA-1:0] mem [OUT_DEPTH];

            assign infl[gi]       = tag_v_reg && (tag_ch_reg == 1'(gi));
            assign push[gi]       = infl[gi];
            assign dout_valid[gi] = (occ_reg != '0);
            assign pop[gi]        = dout_valid[gi] && dout_ready[gi];
            assign dout_data[gi]  = mem[rd_ptr_reg];

            // Words already in flight count against the space, so a grant never overfills.
            assign load     = {1'b0, occ_reg} + (OCC_W + 1)'(infl[gi]);
            assign elig[gi] = rst && din_valid[gi] && (load < (OCC_W + 1)'(OUT_DEPTH));

            always_comb begin
                occ_next = occ_reg;
                if (push[gi] && !pop[gi]) begin
                    occ_next = occ_reg + 1'b1;
                end else if (!push[gi] && pop[gi]) begin
                    occ_next = occ_reg - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    occ_reg    <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    occ_reg <= occ_next;
                    if (push[gi]) begin
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= bus.rom_doa;
                end
            end

            a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                !(push[gi] && !pop[gi] && occ_reg == OCC_W'(OUT_DEPTH)));
            a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
                !(pop[gi] && occ_reg == '0));
        end
    endgenerate

    assign busy = (|infl) | (|dout_valid);

endmodule

// File: tb/tb_sqrt_rom_arbiter.sv
// Randomised and directed stimulus against a queue-based model of the sqrt ROM arbiter;
// a negedge monitor predicts grants, busy and in-order results per channel.
module tb_sqrt_rom_arbiter;
    localparam int W_DATA = 16;
    localparam int W_ADDR = 8;
    localparam int DEPTH  = 3;

    typedef struct {
        logic [W_DATA-1:0] data;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    sqrt_rom_arbiter_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();

    sqrt_rom_arbiter #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .OUT_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [W_DATA-1:0] rom [256];
    always @(posedge clk) begin
        if (bus.rom_ena) bus.rom_doa <= rom[bus.rom_addra];
    end

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb [2][$];
    int   outst [2];
    int   acc_cnt [2];
    int   pop_cnt [2];
    int   cyc = 0;
    logic rr_m = 1'b0;

    function automatic logic [W_DATA-1:0] isqrt(input logic [W_ADDR-1:0] a);
        longint n;
        longint r;
        longint t;
        n = longint'(a) << 23;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= n) r = t;
        end
        return W_DATA'(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.din0_valid = 1'b0;
        bus.din1_valid = 1'b0;
        bus.dout0_ready = 1'b1;
        bus.dout1_ready = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [1:0]        v, rdy, dv, drd, elig_m, g_m;
        logic [W_ADDR-1:0] a [2];
        logic [W_DATA-1:0] dd [2];
        logic              edv;
        logic [W_ADDR-1:0] eaddr;
        for (int i = 0; i < 2; i++) begin
            outst[i] = 0;
            acc_cnt[i] = 0;
            pop_cnt[i] = 0;
        end
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    sb[i].delete();
                    outst[i] = 0;
                end
                rr_m = 1'b0;
                if (clk == 1'b0)
                    chk("rst_idle", {bus.dout1_valid, bus.dout0_valid, bus.din1_ready,
                                     bus.din0_ready, bus.rom_ena, busy}, 64'd0);
            end else begin
                v   = {bus.din1_valid, bus.din0_valid};
                rdy = {bus.din1_ready, bus.din0_ready};
                dv  = {bus.dout1_valid, bus.dout0_valid};
                drd = {bus.dout1_ready, bus.dout0_ready};
                a[0] = bus.din0_data;  a[1] = bus.din1_data;
                dd[0] = bus.dout0_data; dd[1] = bus.dout1_data;

                for (int i = 0; i < 2; i++) elig_m[i] = v[i] && (outst[i] < DEPTH);
                if (elig_m == 2'b11) g_m = rr_m ? 2'b10 : 2'b01;
                else                 g_m = elig_m;
                eaddr = g_m[1] ? a[1] : (g_m[0] ? a[0] : '0);

                chk("din_ready", rdy, g_m);
                chk("rom_ena", bus.rom_ena, |g_m);
                chk("rom_addra", bus.rom_addra, eaddr);
                chk("busy", busy, (outst[0] + outst[1]) != 0);

                for (int i = 0; i < 2; i++) begin
                    edv = (sb[i].size() != 0) && (sb[i][0].cyc <= cyc - 2);
                    chk($sformatf("dout%0d_valid", i), dv[i], edv);
                    if (edv && dv[i])
                        chk($sformatf("dout%0d_data", i), dd[i], sb[i][0].data);
                    if (edv && drd[i]) begin
                        void'(sb[i].pop_front());
                        outst[i]--;
                        pop_cnt[i]++;
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (g_m[i]) begin
                        sb[i].push_back('{data: isqrt(a[i]), cyc: cyc});
                        outst[i]++;
                        acc_cnt[i]++;
                        rr_m = (i == 0);
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int a0, p0;
        logic [W_ADDR-1:0] a1, a2;
        int k;
        for (int i = 0; i < 256; i++) rom[i] = W_DATA'($rtoi($sqrt(real'(i) * 8388608.0)));
        bus.din0_data = '0; bus.din1_data = '0;
        idle();
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // traffic, then reset mid-stream
        repeat (20) begin
            bus.din0_valid = 1'($urandom_range(0, 1)); bus.din0_data = W_ADDR'($urandom);
            bus.din1_valid = 1'($urandom_range(0, 1)); bus.din1_data = W_ADDR'($urandom);
            step();
        end
        rst = 1'b0;
        #1 chk("rst_immediate", {bus.dout1_valid, bus.dout0_valid, bus.din1_ready,
                                 bus.din0_ready, bus.rom_ena, busy}, 64'd0);
        idle();
        step();
        rst = 1'b1;
        step();

        // single lookup
        bus.din0_valid = 1'b1; bus.din0_data = 8'd4;
        #1 chk("addr4_rom", {bus.rom_ena, bus.rom_addra}, {1'b1, 8'd4});
        step();
        bus.din0_valid = 1'b0;
        step();
        chk("addr4_dout", {bus.dout0_valid, bus.dout0_data}, {1'b1, 16'h16a0});
        repeat (3) step();

        // streaming on channel 1
        for (int i = 0; i < 256; i++) begin
            bus.din1_valid = 1'b1; bus.din1_data = W_ADDR'(i);
            #1 chk("stream_ready", bus.din1_ready, 1'b1);
            step();
        end
        bus.din1_valid = 1'b0;
        repeat (4) step();

        // contention from reset
        rst = 1'b0;
        bus.din0_valid = 1'b1; bus.din0_data = 8'd64;
        bus.din1_valid = 1'b1; bus.din1_data = 8'd1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 chk("contend_alt", {bus.din1_ready, bus.din0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        idle();
        repeat (4) step();

        // backpressure on channel 0
        a0 = acc_cnt[0];
        bus.dout0_ready = 1'b0;
        repeat (12) begin
            bus.din0_valid = 1'b1; bus.din0_data = W_ADDR'($urandom);
            bus.din1_valid = 1'b1; bus.din1_data = W_ADDR'($urandom);
            step();
        end
        chk("bp_accepts", acc_cnt[0] - a0, DEPTH);
        chk("bp_ready_low", bus.din0_ready, 1'b0);
        bus.din0_valid = 1'b0; bus.din1_valid = 1'b0;
        bus.dout0_ready = 1'b1;
        p0 = pop_cnt[0];
        repeat (6) step();
        chk("bp_drain", pop_cnt[0] - p0, DEPTH);
        bus.din0_valid = 1'b1;
        #1 chk("bp_resume", bus.din0_ready, 1'b1);
        step();
        idle();
        repeat (4) step();

        // simultaneous push and pop at occupancy 1
        a1 = W_ADDR'($urandom); a2 = W_ADDR'($urandom);
        bus.dout0_ready = 1'b0;
        bus.din0_valid = 1'b1; bus.din0_data = a1;
        step();
        bus.din0_data = a2;
        step();
        bus.din0_valid = 1'b0; bus.dout0_ready = 1'b1;
        step();
        bus.dout0_ready = 1'b0;
        chk("pp_head", {bus.dout0_valid, bus.dout0_data}, {1'b1, isqrt(a2)});
        step();
        chk("pp_still1", bus.dout0_valid, 1'b1);
        bus.dout0_ready = 1'b1;
        step();
        chk("pp_empty", bus.dout0_valid, 1'b0);
        idle();
        repeat (2) step();

        // reset with a lookup in flight
        bus.din0_valid = 1'b1; bus.din0_data = 8'd200;
        step();
        bus.din0_valid = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("inflight_dropped", {bus.dout0_valid, busy}, 2'b00);
        end
        bus.din0_valid = 1'b1; bus.din1_valid = 1'b1;
        #1 chk("rr_after_rst", {bus.din1_ready, bus.din0_ready}, 2'b01);
        step();
        idle();
        repeat (4) step();

        // random traffic
        repeat (1500) begin
            bus.din0_valid  = ($urandom_range(0, 3) != 0);
            bus.din1_valid  = ($urandom_range(0, 3) != 0);
            bus.din0_data   = W_ADDR'($urandom);
            bus.din1_data   = W_ADDR'($urandom);
            bus.dout0_ready = ($urandom_range(0, 9) < 7);
            bus.dout1_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        idle();
        k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        chk("drain_busy", busy, 1'b0);
        chk("sb_empty", sb[0].size() + sb[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sqrt_rom_arbiter.md
Name: sqrt_rom_arbiter

Overview:
- Shares one single-port synchronous sqrt lookup ROM (1-cycle read latency, enable-gated) between two independent requester channels.
- Each channel presents an address over valid/ready and receives the table word back over valid/ready, in request order.
- Round-robin arbitration grants at most one ROM read per cycle.
- Per-channel output buffering gives full throughput and keeps any combinational path from dout_ready off din_ready.

Parameters:
- W_DATA, 16: ROM word width, and width of the dout*_data ports.
- W_ADDR, 8: ROM address width, and width of the din*_data ports.
- OUT_DEPTH, 3: entries per channel output FIFO. Must be >= 3; 3 is the minimum that sustains one lookup per cycle per channel.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- din0_data  in  W_ADDR  channel 0 lookup address.
- din0_valid  in  1  channel 0 request valid.
- din0_ready  out  1  channel 0 request accepted this cycle.
- dout0_data  out  W_DATA  channel 0 result (FIFO head).
- dout0_valid  out  1  channel 0 result valid.
- dout0_ready  in  1  channel 0 consumer ready.
- din1_data, din1_valid, din1_ready, dout1_data, dout1_valid, dout1_ready: same as channel 0, for channel 1.
- rom_ena  out  1  ROM read enable.
- rom_addra  out  W_ADDR  ROM read address.
- rom_doa  in  W_DATA  ROM read data, valid the cycle after rom_ena.
- busy  out  1  any lookup in flight or any output FIFO non-empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - occupancy counters occ0/occ1 = 0; FIFOs empty.
  - inflight flags infl0/infl1 = 0; rr pointer = channel 0.
  - dout*_valid = 0, din*_ready = 0, rom_ena = 0, busy = 0.
  - Any lookup in flight is discarded; a rom_doa word arriving after reset release is ignored.
- Eligibility: channel i is eligible iff din_i_valid && (occ_i + infl_i < OUT_DEPTH). Only registered state is used; dout_ready never feeds din_ready.
- Arbitration (combinational, same cycle):
  - If exactly one channel is eligible, it is granted.
  - If both are eligible, the channel named by rr is granted.
  - On a grant to channel i, rr <= 1-i. With no grant, rr holds.
- Grant outputs:
  - din_i_ready = grant_i.
  - rom_ena = grant0 | grant1.
  - rom_addra = granted channel's din_data; 0 when there is no grant.
  - din_ready may depend on din_valid; din_valid must not depend on din_ready.
- Return pipeline:
  - Registered tag: tag_v <= rom_ena, tag_ch <= granted index. infl_i = tag_v && tag_ch==i.
  - In the cycle tag_v=1, rom_doa is pushed into FIFO[tag_ch].
- Latency: request accepted at cycle t -> dout valid at t+2 if the FIFO was empty, otherwise queued behind older entries. Order within a channel is preserved.
- Output FIFO per channel:
  - Depth OUT_DEPTH. dout_data is the head entry; dout_valid = (occ != 0).
  - Pop on dout_valid && dout_ready.
  - Push and pop in the same cycle leave occ unchanged; the head advances and the new word goes to the tail.
  - Push into a full FIFO cannot occur, because eligibility reserves the slot. An assertion must flag it.
- Throughput:
  - Both channels requesting with ready held high: strict alternation, one ROM read per cycle.
  - One channel alone: one lookup per cycle.
- Backpressure: with dout_ready held low, a channel accepts exactly OUT_DEPTH requests, then din_ready stays 0 until a pop.
- busy = infl0 | infl1 | (occ0 != 0) | (occ1 != 0).
- Widths: occ counters are clog2(OUT_DEPTH+1) bits and saturate at neither end. Over/underflow is an assertion failure.

Test Plan:
- Reset and single lookup: rst low mid-stream -> all valids/readies 0 immediately. Then ch0 sends addr 4 -> rom_ena=1, rom_addra=4 same cycle; dout0 = 16'h16a0 two cycles later.
- Streaming, one channel: ch1 sends addr 0..255 back-to-back with dout1_ready=1 -> din1_ready high every cycle; outputs in order, e.g. addr 16 -> 16'h2d41, addr 128 -> 16'h8000, addr 255 -> 16'hb4aa.
- Contention: both channels valid every cycle from reset (ch0 addr 64, ch1 addr 1) -> grants alternate starting with ch0. ch0 sees 16'h5a82 and ch1 sees 16'h0b50, each at half rate.
- Backpressure: dout0_ready=0 while ch0 streams -> exactly 3 accepts, then din0_ready=0 while ch1 keeps full rate. Releasing dout0_ready -> 3 words drain in order, then accepts resume.
- Simultaneous push/pop: FIFO at occ=1 with a push and a pop in the same cycle -> occ stays 1 and the head advances to the newer word.
- Reset with a lookup in flight: assert rst the cycle after a grant -> no dout_valid after release, busy=0, and rr back to ch0.
